// File: rtl/axi_sram_slave_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder:
// response codes, channel FSM states and the default memory window.
package axi_sram_slave_pkg;

    localparam logic [1:0]  RESP_OKAY         = 2'b00;
    localparam logic [1:0]  RESP_DECERR       = 2'b11;
    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_e;

endpackage

// File: rtl/axi_sram_slave_sram.sv
// Word-addressed SRAM with one byte-enable write port and one
// registered read port; a same-edge read returns the pre-write word.
module sram_bytewise #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                re_i,
    input  logic [IDX_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-Lite slave backed by a bytewise SRAM, with independent AW/W
// buffering and a fixed, configurable read latency.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                READ_LAT  = 2
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [1:0]          BRESP,
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP
);

    localparam int                STRB_W = DATA_W / 8;
    localparam int                IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(DEPTH) << 3;
    localparam logic [3:0]        LAT_M1 = 4'(READ_LAT - 1);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    // Holds every READY low for the cycle following a reset edge.
    logic up_q;

    w_state_e          w_state_q;
    logic              aw_full_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic              w_full_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    r_state_e          r_state_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [3:0]        cnt_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;

    logic              aw_hs;
    logic              w_hs;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    assign AWREADY = up_q && (w_state_q == W_IDLE) && !aw_full_q;
    assign WREADY  = up_q && (w_state_q == W_IDLE) && !w_full_q;
    assign ARREADY = up_q && (r_state_q == R_IDLE);
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;

    always_ff @(posedge ACLK) begin
        up_q <= !ARESET;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            aw_full_q <= 1'b0;
            awaddr_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_full_q <= 1'b1;
                        awaddr_q  <= AWADDR;
                    end
                    if (w_hs) begin
                        w_full_q <= 1'b1;
                        wdata_q  <= WDATA;
                        wstrb_q  <= WSTRB;
                    end
                    if ((aw_full_q || aw_hs) && (w_full_q || w_hs)) begin
                        w_state_q <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    aw_full_q <= 1'b0;
                    w_full_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= in_range(awaddr_q) ? RESP_OKAY : RESP_DECERR;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        araddr_q  <= ARADDR;
                        cnt_q     <= LAT_M1;
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rvalid_q  <= 1'b1;
                        rresp_q   <= in_range(araddr_q) ? RESP_OKAY : RESP_DECERR;
                        r_state_q <= R_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        rvalid_q  <= 1'b0;
                        rresp_q   <= RESP_OKAY;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign mem_we = (w_state_q == W_COMMIT) && in_range(awaddr_q);
    assign mem_re = (r_state_q == R_WAIT) && (cnt_q == 4'd0) && in_range(araddr_q);

    sram_bytewise #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_sram (
        .clk_i   (ACLK),
        .we_i    (mem_we),
        .waddr_i (word_idx(awaddr_q)),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .re_i    (mem_re),
        .raddr_i (word_idx(araddr_q)),
        .rdata_o (mem_rdata)
    );

    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;
    assign RVALID = rvalid_q;
    assign RRESP  = rresp_q;
    // A decode error returns zero data rather than a stale array word.
    assign RDATA  = (rvalid_q && rresp_q == RESP_OKAY) ? mem_rdata : '0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed and randomized bus traffic against axi_sram_slave,
// checked against a word-level memory model.
module tb_axi_sram_slave;

    localparam int          DATA_W   = 64;
    localparam int          ADDR_W   = 64;
    localparam int          DEPTH    = 4096;
    localparam logic [63:0] BASE     = 64'h8000_0000;
    localparam int          READ_LAT = 2;

    logic        ACLK;
    logic        ARESET;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] ARADDR;
    logic        RVALID;
    logic        RREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;

    int vectors;
    int miscompares;

    logic [63:0] mem_m [int];

    axi_sram_slave #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .READ_LAT  (READ_LAT)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int skew, input int bhold);
        int          c;
        int          n;
        int          aw_start;
        int          w_start;
        bit          awd;
        bit          wd;
        bit          aw_go;
        bit          w_go;
        logic [1:0]  exp_resp;
        logic [63:0] word;
        exp_resp = in_rng(addr) ? 2'b00 : 2'b11;
        aw_start = (skew > 0) ? skew : 0;
        w_start  = (skew < 0) ? -skew : 0;
        AWADDR = addr;
        WDATA  = data;
        WSTRB  = strb;
        c   = 0;
        awd = 0;
        wd  = 0;
        while (!(awd && wd) && c < 40) begin
            if (wd && !awd) chk("wready_low_until_commit", 64'(WREADY), 64'd0);
            if (awd && !wd) chk("awready_low_until_commit", 64'(AWREADY), 64'd0);
            AWVALID = !awd && (c >= aw_start);
            WVALID  = !wd && (c >= w_start);
            aw_go = AWVALID && AWREADY;
            w_go  = WVALID && WREADY;
            tick();
            c++;
            awd = awd | aw_go;
            wd  = wd | w_go;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk("write_handshake_bound", 64'(awd && wd), 64'd1);
        n = 1;
        while (!BVALID && n < 20) begin
            tick();
            n++;
        end
        chk("b_latency", 64'(n), 64'd2);
        chk("bresp", 64'(BRESP), 64'(exp_resp));
        for (int i = 0; i < bhold; i++) begin
            tick();
            chk("bvalid_hold", 64'(BVALID), 64'd1);
            chk("bresp_hold", 64'(BRESP), 64'(exp_resp));
            chk("awready_hold", 64'(AWREADY), 64'd0);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("bvalid_drop", 64'(BVALID), 64'd0);
        if (in_rng(addr)) begin
            word = mem_m.exists(widx(addr)) ? mem_m[widx(addr)] : 64'd0;
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
            end
            mem_m[widx(addr)] = word;
        end
    endtask

    task automatic do_read(input logic [63:0] addr, input int rhold, output logic [63:0] got);
        int          c;
        int          n;
        bit          done;
        bit          go;
        bit          known;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        exp_resp = in_rng(addr) ? 2'b00 : 2'b11;
        known    = 1'b1;
        exp_data = 64'd0;
        if (in_rng(addr)) begin
            known    = mem_m.exists(widx(addr));
            exp_data = known ? mem_m[widx(addr)] : 64'd0;
        end
        ARADDR  = addr;
        ARVALID = 1'b1;
        c    = 0;
        done = 0;
        while (!done && c < 40) begin
            go = ARREADY;
            tick();
            c++;
            done = go;
        end
        ARVALID = 1'b0;
        chk("ar_handshake_bound", 64'(done), 64'd1);
        n = 0;
        while (!RVALID && n < 40) begin
            tick();
            n++;
        end
        chk("r_latency", 64'(n), 64'(READ_LAT));
        chk("rresp", 64'(RRESP), 64'(exp_resp));
        if (known) chk("rdata", RDATA, exp_data);
        got = RDATA;
        for (int i = 0; i < rhold; i++) begin
            tick();
            chk("rvalid_hold", 64'(RVALID), 64'd1);
            chk("rresp_hold", 64'(RRESP), 64'(exp_resp));
            if (known) chk("rdata_hold", RDATA, exp_data);
            chk("arready_hold", 64'(ARREADY), 64'd0);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        chk("rvalid_drop", 64'(RVALID), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] a;
        logic [63:0] x;
        logic [63:0] y;
        vectors     = 0;
        miscompares = 0;
        ARESET  = 1'b1;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        BREADY  = 1'b0;
        RREADY  = 1'b0;
        AWADDR  = '0;
        WDATA   = '0;
        WSTRB   = '0;
        ARADDR  = '0;

        tick();
        tick();
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_bresp", 64'(BRESP), 64'd0);
        chk("rst_rresp", 64'(RRESP), 64'd0);
        chk("rst_rdata", RDATA, 64'd0);
        ARESET = 1'b0;
        tick();
        chk("post_rst_arready", 64'(ARREADY), 64'd1);
        chk("post_rst_awready", 64'(AWREADY), 64'd1);
        chk("post_rst_wready", 64'(WREADY), 64'd1);

        // Same-cycle AW/W, then read back.
        do_write(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 0);
        do_read(64'h8000_0010, 0, d);
        chk("same_cycle_readback", d, 64'h1122_3344_5566_7788);

        // W three cycles ahead of AW, low-half strobe.
        do_write(64'h8000_0010, 64'hAAAA_AAAA_DEAD_BEEF, 8'h0F, -3, 0);
        do_read(64'h8000_0010, 0, d);
        chk("partial_strobe_readback", d, 64'h1122_3344_DEAD_BEEF);

        // Seed the pool, including the words an out-of-range write could alias.
        for (int k = 0; k < 8; k++) begin
            do_write(BASE + 64'(8 * k), {$urandom, $urandom}, 8'hFF, 0, 0);
        end
        do_write(BASE + 64'(8 * (DEPTH - 1)), {$urandom, $urandom}, 8'hFF, 0, 0);

        do_write(64'h7FFF_FFF8, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 0, 0);
        do_read(64'h8000_8000, 0, d);
        chk("decerr_rdata_zero", d, 64'd0);
        do_read(BASE, 0, d);
        do_read(BASE + 64'(8 * (DEPTH - 1)), 0, d);
        do_read(64'h8000_7FF8, 0, d);

        do_write(64'h8000_0018, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1, 5);
        do_read(64'h8000_0018, 5, d);

        // Read sample and write commit land on the same edge.
        a = 64'h8000_0020;
        x = mem_m[widx(a)];
        y = {$urandom, $urandom};
        chk("hazard_arready", 64'(ARREADY), 64'd1);
        ARADDR  = a;
        ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        AWADDR  = a;
        WDATA   = y;
        WSTRB   = 8'hFF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        tick();
        chk("hazard_rvalid", 64'(RVALID), 64'd1);
        chk("hazard_bvalid", 64'(BVALID), 64'd1);
        chk("hazard_old_data", RDATA, x);
        mem_m[widx(a)] = y;
        RREADY = 1'b1;
        BREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        BREADY = 1'b0;
        do_read(a, 0, d);
        chk("hazard_new_data", d, y);

        // Reset while the read is waiting on the array.
        ARADDR  = 64'h8000_0008;
        ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        ARESET  = 1'b1;
        tick();
        ARESET  = 1'b0;
        chk("midrst_rvalid", 64'(RVALID), 64'd0);
        chk("midrst_arready", 64'(ARREADY), 64'd0);
        tick();
        chk("midrst_arready_back", 64'(ARREADY), 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_stale_r", 64'(RVALID), 64'd0);
            tick();
        end

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(9))
                0: a = 64'h7FFF_FFF8;
                1: a = 64'h8000_8000;
                2: a = BASE + 64'(8 * (DEPTH - 1));
                default: a = BASE + 64'(8 * $urandom_range(7));
            endcase
            a = a | 64'($urandom_range(7));
            if ($urandom_range(1) == 1) begin
                do_write(a, {$urandom, $urandom}, 8'($urandom),
                         int'($urandom_range(4)) - 2, int'($urandom_range(2)));
            end else begin
                do_read(a, int'($urandom_range(2)), d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
